// File: rtl/add_n_pkg.sv
// Shared sizing helpers for the N-input FIFO adder: accumulator width and
// signed range limits used by the saturation stage.
package add_n_pkg;

    localparam int SAT_CNT_W = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // One extra bit beyond the growth bits so that negating -2^(w-1) is exact.
    function automatic int acc_width(input int num_in, input int data_width);
        return data_width + clog2(num_in) + 1;
    endfunction

    function automatic logic signed [63:0] max_pos(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] min_neg(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/add_n_inputs_sat_shift.sv
// Combinational formatter: arithmetic right shift (floor) of the wide sum,
// then clamp to or wrap into the DATA_WIDTH signed range.
module add_n_inputs_sat_shift
    import add_n_pkg::*;
#(
    parameter int ACC_W      = 35,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_SHIFT  = 0,
    parameter bit SATURATE   = 1'b1
) (
    input  logic signed [ACC_W-1:0]      sum_in,
    output logic        [DATA_WIDTH-1:0] res_out,
    output logic                         clamped
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(max_pos(DATA_WIDTH));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(min_neg(DATA_WIDTH));

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = sum_in >>> OUT_SHIFT;
        res_out = shifted[DATA_WIDTH-1:0];
        clamped = 1'b0;
        if (SATURATE) begin
            if (shifted > MAX_V) begin
                res_out = MAX_V[DATA_WIDTH-1:0];
                clamped = 1'b1;
            end else if (shifted < MIN_V) begin
                res_out = MIN_V[DATA_WIDTH-1:0];
                clamped = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_n_inputs.sv
// Pops NUM_IN FWFT FIFOs in lockstep, adds/subtracts per SUB_MASK, shifts and
// saturates/wraps into an output FIFO. Pop-to-write latency 2, full backpressure.
module add_n_inputs
    import add_n_pkg::*;
#(
    parameter int                NUM_IN     = 2,
    parameter int                DATA_WIDTH = 32,
    parameter logic [NUM_IN-1:0] SUB_MASK   = '0,
    parameter int                OUT_SHIFT  = 0,
    parameter bit                SATURATE   = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic [NUM_IN-1:0]            in_rd_en,
    input  logic [NUM_IN-1:0]            in_empty,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
    output logic                         out_wr_en,
    input  logic                         out_full,
    output logic [DATA_WIDTH-1:0]        out_din,
    output logic [SAT_CNT_W-1:0]         sat_count
);

    localparam int ACC_W = acc_width(NUM_IN, DATA_WIDTH);

    logic                          s0_valid_q, s0_valid_d;
    logic [NUM_IN-1:0][ACC_W-1:0]  s0_ops_q, s0_ops_d;
    logic                          s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]         s1_res_q, s1_res_d;
    logic [SAT_CNT_W-1:0]          sat_count_q, sat_count_d;

    logic                          pop;
    logic                          s0_advance;
    logic                          wr;
    logic signed [ACC_W-1:0]       op_ext;
    logic signed [ACC_W-1:0]       sum;
    logic [DATA_WIDTH-1:0]         fmt_res;
    logic                          fmt_clamped;

    // Handshake terms are gated by reset so the FIFO strobes drop immediately.
    always_comb begin
        wr         = reset && s1_valid_q && !out_full;
        s0_advance = s0_valid_q && (!s1_valid_q || wr);
        pop        = reset && (in_empty == '0) && (!s0_valid_q || s0_advance);
    end

    always_comb begin
        s0_ops_d = s0_ops_q;
        op_ext   = '0;
        if (pop) begin
            for (int i = 0; i < NUM_IN; i++) begin
                op_ext      = ACC_W'($signed(in_dout[i*DATA_WIDTH +: DATA_WIDTH]));
                s0_ops_d[i] = SUB_MASK[i] ? -op_ext : op_ext;
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            sum = sum + $signed(s0_ops_q[i]);
        end
    end

    add_n_inputs_sat_shift #(
        .ACC_W      (ACC_W),
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_SHIFT  (OUT_SHIFT),
        .SATURATE   (SATURATE)
    ) u_sat_shift (
        .sum_in  (sum),
        .res_out (fmt_res),
        .clamped (fmt_clamped)
    );

    always_comb begin
        s0_valid_d  = s0_valid_q;
        s1_valid_d  = s1_valid_q;
        s1_res_d    = s1_res_q;
        sat_count_d = sat_count_q;

        if (pop) begin
            s0_valid_d = 1'b1;
        end else if (s0_advance) begin
            s0_valid_d = 1'b0;
        end

        if (s0_advance) begin
            s1_valid_d = 1'b1;
            s1_res_d   = fmt_res;
            if (fmt_clamped && (sat_count_q != '1)) begin
                sat_count_d = sat_count_q + 1'b1;
            end
        end else if (wr) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s0_valid_q  <= 1'b0;
            s0_ops_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_res_q    <= '0;
            sat_count_q <= '0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_ops_q    <= s0_ops_d;
            s1_valid_q  <= s1_valid_d;
            s1_res_q    <= s1_res_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign in_rd_en  = {NUM_IN{pop}};
    assign out_wr_en = wr;
    assign out_din   = s1_res_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_add_n_inputs.sv
// Directed bench for add_n_inputs across several parameterisations.
module tb_add_n_inputs;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    int n_tot = 0;
    int n_bad = 0;

    // 2-input, 32-bit, add/add
    logic [1:0]  rd2, e2;
    logic [63:0] d2;
    logic        wr2, f2;
    logic [31:0] o2;
    logic [15:0] sc2;

    // 4-input, 32-bit, mask 1010
    logic [3:0]   rd4, e4;
    logic [127:0] d4;
    logic         wr4;
    logic [31:0]  o4;
    logic [15:0]  sc4;

    // four 2-input, 16-bit instances: 0 sat, 1 sat+shift1, 2 sat mask 01, 3 wrap
    logic [3:0][1:0]  rd16, e16;
    logic [3:0][31:0] d16;
    logic [3:0]       wr16;
    logic [3:0][15:0] o16, sc16;

    add_n_inputs #(.NUM_IN(2), .DATA_WIDTH(32)) u_add2 (
        .clock(clock), .reset(reset), .in_rd_en(rd2), .in_empty(e2), .in_dout(d2),
        .out_wr_en(wr2), .out_full(f2), .out_din(o2), .sat_count(sc2));

    add_n_inputs #(.NUM_IN(4), .DATA_WIDTH(32), .SUB_MASK(4'b1010)) u_sub4 (
        .clock(clock), .reset(reset), .in_rd_en(rd4), .in_empty(e4), .in_dout(d4),
        .out_wr_en(wr4), .out_full(1'b0), .out_din(o4), .sat_count(sc4));

    add_n_inputs #(.NUM_IN(2), .DATA_WIDTH(16)) u_sat (
        .clock(clock), .reset(reset), .in_rd_en(rd16[0]), .in_empty(e16[0]), .in_dout(d16[0]),
        .out_wr_en(wr16[0]), .out_full(1'b0), .out_din(o16[0]), .sat_count(sc16[0]));

    add_n_inputs #(.NUM_IN(2), .DATA_WIDTH(16), .OUT_SHIFT(1)) u_sh1 (
        .clock(clock), .reset(reset), .in_rd_en(rd16[1]), .in_empty(e16[1]), .in_dout(d16[1]),
        .out_wr_en(wr16[1]), .out_full(1'b0), .out_din(o16[1]), .sat_count(sc16[1]));

    add_n_inputs #(.NUM_IN(2), .DATA_WIDTH(16), .SUB_MASK(2'b01)) u_neg (
        .clock(clock), .reset(reset), .in_rd_en(rd16[2]), .in_empty(e16[2]), .in_dout(d16[2]),
        .out_wr_en(wr16[2]), .out_full(1'b0), .out_din(o16[2]), .sat_count(sc16[2]));

    add_n_inputs #(.NUM_IN(2), .DATA_WIDTH(16), .SATURATE(1'b0)) u_wrap (
        .clock(clock), .reset(reset), .in_rd_en(rd16[3]), .in_empty(e16[3]), .in_dout(d16[3]),
        .out_wr_en(wr16[3]), .out_full(1'b0), .out_din(o16[3]), .sat_count(sc16[3]));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a write on u_add2, checking the written value.
    task automatic wait_wr2(input string tag, input longint exp);
        int seen;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            if (wr2) begin
                seen = 1;
                chk(tag, $signed(o2), exp);
            end else begin
                @(posedge clock); #2;
            end
        end
        if (seen == 0) chk({tag, "_timeout"}, seen, 1);
    endtask

    // Push one pair into 16-bit instance k and check its single result.
    task automatic one16(input int k, input logic [15:0] a, input logic [15:0] b,
                         input longint exp, input string tag);
        int seen;
        @(posedge clock); #1;
        d16[k] = {b, a};
        e16[k] = 2'b00;
        @(posedge clock); #1;
        e16[k] = 2'b11;
        seen = 0;
        for (int c = 0; c < 8 && seen == 0; c++) begin
            #3;
            if (wr16[k]) begin
                seen = 1;
                chk(tag, $signed(o16[k]), exp);
            end else begin
                @(posedge clock); #1;
            end
        end
        if (seen == 0) chk({tag, "_timeout"}, seen, 1);
    endtask

    int     sa [200];
    int     sb [200];
    longint gold [200];
    int     idx, oi, extra, nwr;

    initial begin
        reset = 1'b0;
        e2 = 2'b00; d2 = '0; f2 = 1'b0;
        e4 = 4'hF;  d4 = '0;
        e16 = '1;   d16 = '0;

        // reset state, with inputs offered to prove pop is held off
        repeat (2) @(posedge clock);
        #2;
        chk("rst_rd_en", rd2, 0);
        chk("rst_wr_en", wr2, 0);
        chk("rst_din", o2, 0);
        chk("rst_sat", sc2, 0);
        e2 = 2'b11;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // basic add: pops in T and T+1, writes in T+2 and T+3
        d2 = {32'sd4, 32'sd3}; e2 = 2'b00;
        #1 chk("add_pop0", rd2, 2'b11);
        @(posedge clock); #1;
        d2 = {32'sd7, -32'sd10};
        #1 chk("add_pop1", rd2, 2'b11);
        chk("add_wr_t1", wr2, 0);
        @(posedge clock); #1;
        e2 = 2'b11;
        #1 chk("add_wr_t2", wr2, 1);
        chk("add_sum0", $signed(o2), 7);
        @(posedge clock); #2;
        chk("add_wr_t3", wr2, 1);
        chk("add_sum1", $signed(o2), -3);
        @(posedge clock); #2;
        chk("add_wr_t4", wr2, 0);
        chk("add_sat", sc2, 0);

        // 4-channel add/subtract
        @(posedge clock); #1;
        d4 = {32'sd1, 32'sd5, 32'sd30, 32'sd100}; e4 = 4'h0;
        #1 chk("sub4_pop", rd4, 4'hF);
        @(posedge clock); #1;
        d4 = {-32'sd2, 32'sd0, 32'sd7, -32'sd5};
        @(posedge clock); #1;
        e4 = 4'hF;
        #1 chk("sub4_res0", $signed(o4), 74);
        chk("sub4_wr0", wr4, 1);
        @(posedge clock); #2;
        chk("sub4_res1", $signed(o4), -10);
        chk("sub4_sat", sc4, 0);

        // saturation, shift, exact negation of the most negative value, wrap
        one16(0, 16'h7FFF, 16'h7FFF, 32767, "sat_pos");
        chk("sat_cnt1", sc16[0], 1);
        one16(0, 16'h8000, 16'hFFFF, -32768, "sat_neg");
        chk("sat_cnt2", sc16[0], 2);
        one16(1, 16'h7FFF, 16'h7FFF, 32767, "shift_pos");
        chk("shift_cnt", sc16[1], 0);
        one16(1, 16'h8000, 16'h8001, -32768, "shift_floor");
        one16(2, 16'h8000, 16'h8000, 0, "neg_exact");
        chk("neg_cnt", sc16[2], 0);
        one16(3, 16'h7FFF, 16'h0001, -32768, "wrap_res");
        chk("wrap_cnt", sc16[3], 0);

        // skew: channel 1 empty while channel 0 holds data
        @(posedge clock); #1;
        d2 = {32'sd2, 32'sd40}; e2 = 2'b10;
        for (int c = 0; c < 5; c++) begin
            #1 chk("skew_hold", rd2, 0);
            @(posedge clock); #1;
        end
        e2 = 2'b00;
        #1 chk("skew_pop", rd2, 2'b11);
        @(posedge clock); #1;
        e2 = 2'b11;
        @(posedge clock); #2;
        wait_wr2("skew_res", 42);

        // backpressure stream
        for (int i = 0; i < 200; i++) begin
            sa[i]   = int'($urandom_range(0, 65535)) - 32768;
            sb[i]   = int'($urandom_range(0, 65535)) - 32768;
            gold[i] = longint'(sa[i]) + longint'(sb[i]);
        end
        idx = 0; oi = 0; extra = 0;
        for (int c = 0; c < 4000 && oi < 200; c++) begin
            @(posedge clock); #1;
            f2 = ($urandom_range(0, 2) == 0);
            if (idx < 200 && $urandom_range(0, 4) != 0) begin
                e2 = 2'b00;
                d2 = {sb[idx], sa[idx]};
            end else begin
                e2 = 2'b11;
            end
            #3;
            if (rd2 == 2'b11) idx++;
            if (wr2) begin
                chk("bp_data", $signed(o2), gold[oi]);
                oi++;
            end
        end
        e2 = 2'b11; f2 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #3;
            if (wr2) extra++;
        end
        chk("bp_writes", oi, 200);
        chk("bp_pops", idx, 200);
        chk("bp_extra", extra, 0);
        chk("bp_sat", sc2, 0);

        // reset with two samples in flight
        @(posedge clock); #1;
        d2 = {32'sd22, 32'sd11}; e2 = 2'b00;
        @(posedge clock); #1;
        d2 = {32'sd44, 32'sd33};
        @(posedge clock); #1;
        #1 chk("inflight_wr", wr2, 1);
        reset = 1'b0;
        #1 chk("rst_mid_wr", wr2, 0);
        chk("rst_mid_rd", rd2, 0);
        chk("rst_mid_sat", sc2, 0);
        chk("rst_mid_cnt16", sc16[0], 0);
        @(posedge clock); #1;
        reset = 1'b1; e2 = 2'b11;
        nwr = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #3;
            if (wr2) nwr++;
        end
        chk("post_rst_quiet", nwr, 0);
        @(posedge clock); #1;
        d2 = {32'sd6, 32'sd5}; e2 = 2'b00;
        @(posedge clock); #1;
        d2 = {32'sd2, 32'sd1};
        @(posedge clock); #1;
        e2 = 2'b11;
        #1 chk("post_rst_wr", wr2, 1);
        chk("post_rst_res0", $signed(o2), 11);
        @(posedge clock); #2;
        wait_wr2("post_rst_res1", 3);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_tot, n_bad);
        $fatal(1);
    end

endmodule
